fetch_sequencer: RTL and testbench

//  Upstream control stage that drives the command/data memory request bus and the alu operand bus.

---
 rtl/fetch_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Upstream control stage. For each 16-bit command it fetches
//                the command word, reads two operands, hands them to the alu,
//                and writes the result back over the shared request bus.
//                Command layout: [15:13] op, [12:9] srcA, [8:5] srcB,
//                [4:1] dst, [0] next (1 = continue with pc+1, 0 = halt).
//
//  Ports       : clk, rst_n          clock / async active-low reset
//                start               1-cycle pulse, runs from pc=0 (IDLE/HALT)
//                give_com            command read strobe, adr = pc
//                give_data           operand read strobe, adr = operand addr
//                write               write-back strobe, adr = dst, then result
//                adr                 address / write-back data bus
//                dv, com, data       memory response
//                alu_dvi, alu_op,
//                alu_a, alu_b        alu request
//                alu_dvo, alu_p      alu response
//                busy, halted, pc    status
//                err                 sticky timeout flag
//
//  Macro       : FETCH_SEQ_TIMEOUT_EN - enables the per-WAIT-state timeout
//                (TIMEOUT_CYC cycles) that sets err and forces HALT. When
//                undefined, WAIT states wait forever and err is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int AW          = 4,
    parameter int DW          = 4,
    parameter int CW          = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          give_com,
    output logic          give_data,
    output logic          write,
    output logic [AW-1:0] adr,
    input  logic          dv,
    input  logic [CW-1:0] com,
    input  logic [DW-1:0] data,
    output logic          alu_dvi,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic          alu_dvo,
    input  logic [DW-1:0] alu_p,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_OPA_REQ    = 4'd3,
        S_OPA_WAIT   = 4'd4,
        S_OPB_REQ    = 4'd5,
        S_OPB_WAIT   = 4'd6,
        S_EXEC       = 4'd7,
        S_EXEC_WAIT  = 4'd8,
        S_WB_ADR     = 4'd9,
        S_WB_DATA    = 4'd10,
        S_HALT       = 4'd11
    } state_t;

    state_t        r_state;
    logic [3:0]    r_srcb;
    logic [3:0]    r_dst;
    logic          r_next;
    logic [DW-1:0] r_res;

    logic w_start_ok;
    logic w_tmo;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_cnt;
    logic          w_in_wait;
    logic          w_resp;

    assign w_in_wait = (r_state == S_FETCH_WAIT) || (r_state == S_OPA_WAIT) ||
                       (r_state == S_OPB_WAIT)   || (r_state == S_EXEC_WAIT);
    assign w_resp    = (dv && ((r_state == S_FETCH_WAIT) || (r_state == S_OPA_WAIT) ||
                               (r_state == S_OPB_WAIT))) ||
                       (alu_dvo && (r_state == S_EXEC_WAIT));
    // The counter reads 0 in the first cycle of a WAIT state, so the
    // timeout fires in the TIMEOUT_CYC-th cycle spent waiting.
    assign w_tmo     = w_in_wait && !w_resp && (r_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_wait) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_start_ok) begin
            err <= 1'b0;
        end else if (w_tmo) begin
            err <= 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYC > 0);
    assign w_tmo        = 1'b0;
    assign err          = 1'b0;
`endif

    // Outputs are registered and assigned on the transition into the state
    // they belong to, so each strobe is high exactly during its REQ state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_srcb    <= '0;
            r_dst     <= '0;
            r_next    <= 1'b0;
            r_res     <= '0;
            give_com  <= 1'b0;
            give_data <= 1'b0;
            write     <= 1'b0;
            adr       <= '0;
            alu_dvi   <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            pc        <= '0;
        end else begin
            give_com  <= 1'b0;
            give_data <= 1'b0;
            write     <= 1'b0;
            alu_dvi   <= 1'b0;

            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state  <= S_FETCH_REQ;
                        pc       <= '0;
                        adr      <= '0;
                        give_com <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end

                S_FETCH_REQ: r_state <= S_FETCH_WAIT;

                S_FETCH_WAIT: begin
                    if (dv) begin
                        alu_op    <= com[15:13];
                        r_srcb    <= com[8:5];
                        r_dst     <= com[4:1];
                        r_next    <= com[0];
                        adr       <= AW'(com[12:9]);
                        give_data <= 1'b1;
                        r_state   <= S_OPA_REQ;
                    end else if (w_tmo) begin
                        r_state <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end
                end

                S_OPA_REQ: r_state <= S_OPA_WAIT;

                S_OPA_WAIT: begin
                    if (dv) begin
                        alu_a     <= data;
                        adr       <= AW'(r_srcb);
                        give_data <= 1'b1;
                        r_state   <= S_OPB_REQ;
                    end else if (w_tmo) begin
                        r_state <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end
                end

                S_OPB_REQ: r_state <= S_OPB_WAIT;

                S_OPB_WAIT: begin
                    if (dv) begin
                        alu_b   <= data;
                        alu_dvi <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (w_tmo) begin
                        r_state <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end
                end

                S_EXEC: r_state <= S_EXEC_WAIT;

                S_EXEC_WAIT: begin
                    if (alu_dvo) begin
                        r_res   <= alu_p;
                        adr     <= AW'(r_dst);
                        write   <= 1'b1;
                        r_state <= S_WB_ADR;
                    end else if (w_tmo) begin
                        r_state <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end
                end

                // Second write-back beat carries the result on the address bus.
                S_WB_ADR: begin
                    adr     <= AW'(r_res);
                    r_state <= S_WB_DATA;
                end

                S_WB_DATA: begin
                    if (r_next) begin
                        pc       <= pc + 1'b1;
                        adr      <= pc + 1'b1;
                        give_com <= 1'b1;
                        r_state  <= S_FETCH_REQ;
                    end else begin
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A bus-level memory
//                and alu environment answers requests; a command-level
//                reference model predicts the ordered bus events, cycle
//                counts, final pc and memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int K_COM = 1 << 12;
    localparam int K_DAT = 2 << 12;
    localparam int K_ALU = 3 << 12;
    localparam int K_WA  = 4 << 12;
    localparam int K_WD  = 5 << 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        give_com, give_data, write;
    logic [3:0]  adr;
    logic        dv;
    logic [15:0] com;
    logic [3:0]  data;
    logic        alu_dvi;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a, alu_b;
    logic        alu_dvo;
    logic [3:0]  alu_p;
    logic        busy, halted;
    logic [3:0]  pc;
    logic        err;

    fetch_sequencer #(.AW(4), .DW(4), .CW(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .give_com(give_com), .give_data(give_data), .write(write), .adr(adr),
        .dv(dv), .com(com), .data(data),
        .alu_dvi(alu_dvi), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_dvo(alu_dvo), .alu_p(alu_p),
        .busy(busy), .halted(halted), .pc(pc), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_com_cyc = -1;
    int          wr_cnt = 0;
    int          stall_total = 0;
    int          opa_stall = 0;
    bit          rnd_stall = 0;
    bit          alu_off = 0;
    logic [15:0] cmem [16];
    logic [3:0]  dmem [16];
    logic [3:0]  m_dmem [16];
    int          ev_q [$];
    int          exp_q [$];
    int          com_q [$];

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return ~a;
        endcase
    endfunction

    function automatic int ev(input int k, input logic [11:0] v);
        return k + int'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command-level model: walks the program and lists the bus events.
    task automatic model(input int max_cmd, output int ncmd, output int pc_end);
        int          p;
        logic [15:0] c;
        logic [3:0]  a, b, r;
        m_dmem = dmem;
        exp_q.delete();
        p    = 0;
        ncmd = 0;
        for (int k = 0; k < max_cmd; k++) begin
            c = cmem[p];
            a = m_dmem[c[12:9]];
            b = m_dmem[c[8:5]];
            r = alu_f(c[15:13], a, b);
            exp_q.push_back(ev(K_COM, 12'(p)));
            exp_q.push_back(ev(K_DAT, {8'd0, c[12:9]}));
            exp_q.push_back(ev(K_DAT, {8'd0, c[8:5]}));
            exp_q.push_back(ev(K_ALU, {1'b0, c[15:13], a, b}));
            exp_q.push_back(ev(K_WA, {8'd0, c[4:1]}));
            exp_q.push_back(ev(K_WD, {8'd0, r}));
            m_dmem[c[4:1]] = r;
            ncmd++;
            if (!c[0]) break;
            p = (p + 1) % 16;
        end
        pc_end = p;
    endtask

    task automatic chk_events(input string tag, input bit prefix);
        int n;
        if (!prefix) chk({tag, "_nev"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            cmem[i] = '0;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start, waits (bounded) for halted; dur = cycles from first
    // give_com to halted. poke >= 0 issues an extra start pulse mid-run.
    task automatic run_prog(input string tag, input int max_cyc, input int poke,
                            output int dur);
        int hc;
        ev_q.delete();
        com_q.delete();
        first_com_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (halted) begin
                hc = cyc;
                break;
            end
            start = (i == poke);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_halted"}, halted, 1'b1);
        dur = hc - first_com_cyc;
        if (hc < 0) do_reset();
    endtask

    // Memory: answers each request after 1 + stall cycles with a 1-cycle dv.
    initial begin : mem_resp
        logic [3:0] a;
        bit         isc;
        int         st;
        int         dcnt;
        dv   = 1'b0;
        com  = '0;
        data = '0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            dv = 1'b0;
            if (give_com || give_data) begin
                a   = adr;
                isc = give_com;
                if (isc) dcnt = 0;
                else     dcnt++;
                st = 0;
                if (!isc && dcnt == 1 && opa_stall > 0) begin
                    st        = opa_stall;
                    opa_stall = 0;
                end else if (rnd_stall) begin
                    st = int'($urandom_range(0, 3));
                end
                stall_total += st;
                repeat (st) @(negedge clk);
                @(negedge clk);
                if (isc) com = cmem[a];
                else     data = dmem[a];
                dv = 1'b1;
            end
        end
    end

    initial begin : alu_resp
        logic [2:0] op;
        logic [3:0] a, b;
        int         st;
        alu_dvo = 1'b0;
        alu_p   = '0;
        forever begin
            @(negedge clk);
            alu_dvo = 1'b0;
            if (alu_dvi && !alu_off) begin
                op = alu_op;
                a  = alu_a;
                b  = alu_b;
                st = rnd_stall ? int'($urandom_range(0, 2)) : 0;
                stall_total += st;
                repeat (st) @(negedge clk);
                @(negedge clk);
                alu_p   = alu_f(op, a, b);
                alu_dvo = 1'b1;
            end
        end
    end

    initial begin : cyc_cnt
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Bus monitor: records events and commits write-backs to memory.
    initial begin : monitor
        logic       wb_pend;
        logic [3:0] wb_adr;
        wb_pend = 1'b0;
        wb_adr  = '0;
        forever begin
            @(negedge clk);
            if (wb_pend) begin
                ev_q.push_back(ev(K_WD, {8'd0, adr}));
                dmem[wb_adr] = adr;
                wb_pend      = 1'b0;
            end
            if (give_com) begin
                ev_q.push_back(ev(K_COM, {8'd0, adr}));
                com_q.push_back(int'(adr));
                if (first_com_cyc < 0) first_com_cyc = cyc;
            end
            if (give_data) ev_q.push_back(ev(K_DAT, {8'd0, adr}));
            if (alu_dvi)   ev_q.push_back(ev(K_ALU, {1'b0, alu_op, alu_a, alu_b}));
            if (write) begin
                ev_q.push_back(ev(K_WA, {8'd0, adr}));
                wr_cnt++;
                wb_pend = 1'b1;
                wb_adr  = adr;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  n, pe, dur, w0;
        bit  seen;
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_all", {give_com, give_data, write, adr, alu_dvi, alu_op, alu_a, alu_b},
            '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Single command: 1 + 4 -> mem[3]
        clear_mem();
        cmem[0] = 16'h0846;
        dmem[4] = 4'd1;
        dmem[2] = 4'd4;
        model(64, n, pe);
        run_prog("single", 100, -1, dur);
        chk_events("single", 1'b0);
        chk("single_cyc", dur, 10);
        chk("single_pc", pc, 4'd0);
        chk("single_alu_a", alu_a, 4'd1);
        chk("single_alu_b", alu_b, 4'd4);
        chk("single_mem3", dmem[3], 4'd5);
        chk("single_busy", busy, 1'b0);

        // Two commands
        clear_mem();
        cmem[0] = 16'h0847;
        cmem[1] = 16'h0C46;
        dmem[4] = 4'd1;
        dmem[2] = 4'd4;
        dmem[6] = 4'd7;
        model(64, n, pe);
        run_prog("two", 100, -1, dur);
        chk_events("two", 1'b0);
        chk("two_cyc", dur, 20);
        chk("two_pc", pc, 4'd1);
        chk("two_mem3", dmem[3], 4'd11);

        // Operand stall of 20 cycles with a start pulse during the stall
        clear_mem();
        cmem[0] = 16'h0846;
        dmem[4] = 4'd1;
        dmem[2] = 4'd4;
        model(64, n, pe);
        opa_stall = 20;
        run_prog("stall", 200, 10, dur);
        chk_events("stall", 1'b0);
        chk("stall_cyc", dur, 30);
        chk("stall_mem3", dmem[3], 4'd5);
        chk("stall_ncom", com_q.size(), 1);

        // pc wrap: every command continues
        for (int i = 0; i < 16; i++) begin
            cmem[i] = 16'($urandom) | 16'h0001;
            dmem[i] = 4'($urandom);
        end
        model(17, n, pe);
        ev_q.delete();
        com_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && com_q.size() < 17; i++) @(negedge clk);
        chk("wrap_ncom", (com_q.size() >= 17), 1'b1);
        if (com_q.size() >= 17) begin
            chk("wrap_pc15", com_q[15], 15);
            chk("wrap_pc0", com_q[16], 0);
        end
        chk_events("wrap", 1'b1);
        do_reset();

        // Asynchronous reset in the middle of EXEC
        clear_mem();
        cmem[0] = 16'h0846;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (alu_dvi) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mrst_exec_seen", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_outs", {give_com, give_data, write, adr, alu_dvi, alu_op, alu_a, alu_b,
                          busy, halted, pc, err}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        chk("mrst_no_write", wr_cnt, w0);
        chk("mrst_idle", {busy, halted}, 2'b00);

        // Randomized programs with random response stalls
        rnd_stall = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int nc;
            nc = int'($urandom_range(1, 16));
            for (int k = 0; k < 16; k++) begin
                cmem[k] = 16'($urandom);
                dmem[k] = 4'($urandom);
            end
            for (int k = 0; k < nc; k++) cmem[k][0] = (k != nc - 1);
            model(64, n, pe);
            stall_total = 0;
            run_prog($sformatf("rnd%0d", r), nc * 30 + 50, -1, dur);
            chk_events($sformatf("rnd%0d", r), 1'b0);
            chk($sformatf("rnd%0d_cyc", r), dur, 10 * n + stall_total);
            chk($sformatf("rnd%0d_pc", r), pc, pe);
            chk($sformatf("rnd%0d_busy", r), busy, 1'b0);
        end
        rnd_stall = 1'b0;

`ifdef FETCH_SEQ_TIMEOUT_EN
        // alu never answers: timeout after 8 cycles in EXEC_WAIT
        clear_mem();
        cmem[0] = 16'h0846;
        alu_off = 1'b1;
        w0 = wr_cnt;
        run_prog("tmo", 80, -1, dur);
        chk("tmo_cyc", dur, 15);
        chk("tmo_err", err, 1'b1);
        chk("tmo_no_write", wr_cnt, w0);
        chk("tmo_nev", ev_q.size(), 4);
        chk("tmo_pc", pc, 4'd0);
        alu_off = 1'b0;
        repeat (3) @(negedge clk);
        model(64, n, pe);
        run_prog("tmo_restart", 100, -1, dur);
        chk("tmo_restart_err", err, 1'b0);
        chk_events("tmo_restart", 1'b0);
`else
        chk("err_tied_low", err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
